// File: rtl/stim_pattern_gen_if.sv
// Handshake/stimulus bundle for stim_pattern_gen.
// master: the block requesting bursts and consuming patterns (e.g. a testbench).
// slave:  the pattern generator itself.
// The pause signal exists only when STIM_PAUSE_EN is defined.
interface stim_pattern_gen_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             stim_valid;
    logic             stim_in1;
    logic             stim_in2;
    logic             stim_in3;
`ifdef STIM_PAUSE_EN
    logic             pause;
`endif

    modport master (
`ifdef STIM_PAUSE_EN
        output pause,
`endif
        output start,
        output len,
        output mode,
        input  busy,
        input  done,
        input  stim_valid,
        input  stim_in1,
        input  stim_in2,
        input  stim_in3
    );

    modport slave (
`ifdef STIM_PAUSE_EN
        input  pause,
`endif
        input  start,
        input  len,
        input  mode,
        output busy,
        output done,
        output stim_valid,
        output stim_in1,
        output stim_in2,
        output stim_in3
    );
endinterface

// File: rtl/stim_pattern_gen.sv
// Stimulus sequencer: on start emits a burst of len 3-bit patterns from one of four sources
// (LFSR, walking one, counter, alternating 000/111), each with a valid strobe, then pulses done.
// Optional feature macro: STIM_PAUSE_EN adds a pause input that stalls emission in RUN.
module stim_pattern_gen #(
    parameter int unsigned        LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1,
    parameter int unsigned        CNT_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    stim_pattern_gen_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [1:0]          mode_q, mode_d;
    logic [2:0]          pat_q, pat_d;
    logic [2:0]          pat_first;
    logic [2:0]          pat_next;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                hold;
    logic                lfsr_fb;

`ifdef STIM_PAUSE_EN
    assign hold = bus.pause;
`else
    assign hold = 1'b0;
`endif

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
    always_comb begin
        lfsr_fb   = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-3] ^ lfsr_q[LFSR_W-4] ^ lfsr_q[LFSR_W-6];
        lfsr_step = {lfsr_q[LFSR_W-2:0], lfsr_fb};
    end

    // Pattern 0 of a burst, chosen by the mode presented alongside start.
    always_comb begin
        pat_first = 3'b000;
        unique case (bus.mode)
            2'd0:    pat_first = SEED[2:0];
            2'd1:    pat_first = 3'b001;
            2'd2:    pat_first = 3'b000;
            2'd3:    pat_first = 3'b000;
            default: pat_first = 3'b000;
        endcase
    end

    // Successor pattern, derived from the one currently presented so no index register is needed.
    always_comb begin
        pat_next = pat_q;
        unique case (mode_q)
            2'd0:    pat_next = lfsr_step[2:0];
            2'd1:    pat_next = {pat_q[1:0], pat_q[2]};
            2'd2:    pat_next = pat_q + 3'd1;
            2'd3:    pat_next = ~pat_q;
            default: pat_next = pat_q;
        endcase
    end

    // Next-state and next-output logic; every output is a flop.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    mode_d = bus.mode;
                    lfsr_d = SEED;
                    busy_d = 1'b1;
                    if (bus.len != '0) begin
                        state_d = StRun;
                        count_d = bus.len;
                        pat_d   = pat_first;
                        valid_d = 1'b1;
                    end else begin
                        state_d = StDone;
                        count_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                busy_d = 1'b1;
                if (hold) begin
                    // Stalled: count, LFSR and pattern all keep their values.
                    valid_d = 1'b0;
                end else if (count_q > 1) begin
                    count_d = count_q - 1'b1;
                    lfsr_d  = lfsr_step;
                    pat_d   = pat_next;
                    valid_d = 1'b1;
                end else begin
                    state_d = StDone;
                    count_d = '0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            lfsr_q  <= SEED;
            mode_q  <= 2'd0;
            pat_q   <= 3'b000;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.stim_valid = valid_q;
    assign bus.stim_in1   = pat_q[0];
    assign bus.stim_in2   = pat_q[1];
    assign bus.stim_in3   = pat_q[2];

endmodule
